// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported memory between instruction fetch (IF) and
// load/store (LS). Conflicting requests are granted round-robin; only one
// transaction is in flight at a time. The winning request is registered and
// presented to memory with a valid/ready handshake, after which the arbiter
// waits for the response and routes it back to the requester that owns the
// transaction. If no response arrives within TIMEOUT cycles the transaction
// is aborted with an error response.
//
// Ports
//   clk, rst                        clock, synchronous active-high reset
//   if_req_valid/ready, if_addr     IF read request channel
//   if_resp_valid/err, if_rdata     IF response channel (single-cycle pulse)
//   ls_req_valid/ready, ls_addr,
//   ls_wen, ls_wdata, ls_wmask,
//   ls_rmask                        LS request channel (load or store)
//   ls_resp_valid/err, ls_rdata     LS response channel (single-cycle pulse)
//   mem_req_valid/ready, mem_addr,
//   mem_wen, mem_wdata, mem_wmask,
//   mem_rmask                       registered request towards memory
//   mem_resp_valid, mem_rdata       memory response
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int          ADDR_W   = 32,
   parameter int          DATA_W   = 32,
   parameter int          TIMEOUT  = 255,
   // Read code driven for instruction fetches (word load).
   parameter logic [2:0]  IF_RMASK = 3'b010
) (
   input  logic              clk,
   input  logic              rst,
   // instruction fetch port
   input  logic              if_req_valid,
   output logic              if_req_ready,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_resp_valid,
   output logic              if_resp_err,
   output logic [DATA_W-1:0] if_rdata,
   // load/store port
   input  logic              ls_req_valid,
   output logic              ls_req_ready,
   input  logic [ADDR_W-1:0] ls_addr,
   input  logic              ls_wen,
   input  logic [DATA_W-1:0] ls_wdata,
   input  logic [7:0]        ls_wmask,
   input  logic [2:0]        ls_rmask,
   output logic              ls_resp_valid,
   output logic              ls_resp_err,
   output logic [DATA_W-1:0] ls_rdata,
   // memory port
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_wen,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [7:0]        mem_wmask,
   output logic [2:0]        mem_rmask,
   input  logic              mem_resp_valid,
   input  logic [DATA_W-1:0] mem_rdata
);

   // Counter only needs to reach TIMEOUT-1.
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;
   typedef enum logic       {OWN_IF, OWN_LS}        owner_t;

   state_t              state_q,      state_d;
   owner_t              owner_q,      owner_d;
   owner_t              last_grant_q, last_grant_d;
   logic [CNT_W-1:0]    tmo_cnt_q,    tmo_cnt_d;
   logic [ADDR_W-1:0]   addr_q,       addr_d;
   logic                wen_q,        wen_d;
   logic [DATA_W-1:0]   wdata_q,      wdata_d;
   logic [7:0]          wmask_q,      wmask_d;
   logic [2:0]          rmask_q,      rmask_d;

   // Response of the current transaction before routing to its owner.
   logic                resp_valid;
   logic                resp_err;
   logic [DATA_W-1:0]   resp_rdata;
   logic                grant_if;
   logic                grant_ls;

   // -------------------------------------------------------------------------
   // Next-state and output logic
   // -------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal written here gets a default first so no path
      // leaves it unassigned; otherwise synthesis infers a latch.
      state_d      = state_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      tmo_cnt_d    = tmo_cnt_q;
      addr_d       = addr_q;
      wen_d        = wen_q;
      wdata_d      = wdata_q;
      wmask_d      = wmask_q;
      rmask_d      = rmask_q;
      grant_if      = 1'b0;
      grant_ls      = 1'b0;
      if_req_ready  = 1'b0;
      ls_req_ready  = 1'b0;
      mem_req_valid = 1'b0;
      resp_valid    = 1'b0;
      resp_err      = 1'b0;
      resp_rdata    = '0;

      // While rst is asserted nothing is granted or returned: the cycle's
      // state update is discarded, so any handshake would be a lie.
      if (!rst) begin
         unique case (state_q)
            S_IDLE: begin
               // LS wins a conflict unless it was the last one served.
               grant_ls = ls_req_valid && (!if_req_valid || (last_grant_q == OWN_IF));
               grant_if = if_req_valid && !grant_ls;
               if (grant_ls) begin
                  ls_req_ready = 1'b1;
                  addr_d       = ls_addr;
                  wen_d        = ls_wen;
                  wdata_d      = ls_wdata;
                  wmask_d      = ls_wmask;
                  rmask_d      = ls_rmask;
                  owner_d      = OWN_LS;
                  last_grant_d = OWN_LS;
                  state_d      = S_REQ;
               end else if (grant_if) begin
                  if_req_ready = 1'b1;
                  addr_d       = if_addr;
                  wen_d        = 1'b0;
                  wdata_d      = '0;
                  wmask_d      = '0;
                  rmask_d      = IF_RMASK;
                  owner_d      = OWN_IF;
                  last_grant_d = OWN_IF;
                  state_d      = S_REQ;
               end
            end

            S_REQ: begin
               // No timeout here: memory may stall acceptance indefinitely.
               mem_req_valid = 1'b1;
               if (mem_req_ready) begin
                  tmo_cnt_d = '0;
                  state_d   = S_RESP;
               end
            end

            S_RESP: begin
               if (mem_resp_valid) begin
                  resp_valid = 1'b1;
                  resp_rdata = mem_rdata;
                  state_d    = S_IDLE;
               end else if (tmo_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                  resp_valid = 1'b1;
                  resp_err   = 1'b1;
                  state_d    = S_IDLE;
               end else begin
                  tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
               end
            end

            default: state_d = S_IDLE;
         endcase
      end
   end

   // Route the response to the owner; the other port sees all zeros.
   always_comb begin
      if_resp_valid = 1'b0;
      if_resp_err   = 1'b0;
      if_rdata      = '0;
      ls_resp_valid = 1'b0;
      ls_resp_err   = 1'b0;
      ls_rdata      = '0;
      if (owner_q == OWN_LS) begin
         ls_resp_valid = resp_valid;
         ls_resp_err   = resp_err;
         ls_rdata      = resp_rdata;
      end else begin
         if_resp_valid = resp_valid;
         if_resp_err   = resp_err;
         if_rdata      = resp_rdata;
      end
   end

   // The registered request fields drive memory directly.
   assign mem_addr  = addr_q;
   assign mem_wen   = wen_q;
   assign mem_wdata = wdata_q;
   assign mem_wmask = wmask_q;
   assign mem_rmask = rmask_q;

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments here so every flop samples the
      // pre-edge value of its _d input, independent of statement order.
      if (rst) begin
         state_q      <= S_IDLE;
         owner_q      <= OWN_IF;
         last_grant_q <= OWN_IF;
         tmo_cnt_q    <= '0;
         addr_q       <= '0;
         wen_q        <= 1'b0;
         wdata_q      <= '0;
         wmask_q      <= '0;
         rmask_q      <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         tmo_cnt_q    <= tmo_cnt_d;
         addr_q       <= addr_d;
         wen_q        <= wen_d;
         wdata_q      <= wdata_d;
         wmask_q      <= wmask_d;
         rmask_q      <= rmask_d;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter with TIMEOUT=4. Inputs change 1 time
// unit after the rising edge, outputs are sampled 2 units after it.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

   localparam int ADDR_W  = 32;
   localparam int DATA_W  = 32;
   localparam int TIMEOUT = 4;
   localparam logic [2:0] LW = 3'b010;

   logic              clk = 1'b0;
   logic              rst;
   logic              if_req_valid;
   logic              if_req_ready;
   logic [ADDR_W-1:0] if_addr;
   logic              if_resp_valid;
   logic              if_resp_err;
   logic [DATA_W-1:0] if_rdata;
   logic              ls_req_valid;
   logic              ls_req_ready;
   logic [ADDR_W-1:0] ls_addr;
   logic              ls_wen;
   logic [DATA_W-1:0] ls_wdata;
   logic [7:0]        ls_wmask;
   logic [2:0]        ls_rmask;
   logic              ls_resp_valid;
   logic              ls_resp_err;
   logic [DATA_W-1:0] ls_rdata;
   logic              mem_req_valid;
   logic              mem_req_ready;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_wen;
   logic [DATA_W-1:0] mem_wdata;
   logic [7:0]        mem_wmask;
   logic [2:0]        mem_rmask;
   logic              mem_resp_valid;
   logic [DATA_W-1:0] mem_rdata;

   int errors = 0;
   int checks = 0;

   mem_port_arbiter #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .TIMEOUT (TIMEOUT),
      .IF_RMASK(LW)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .if_req_valid  (if_req_valid),
      .if_req_ready  (if_req_ready),
      .if_addr       (if_addr),
      .if_resp_valid (if_resp_valid),
      .if_resp_err   (if_resp_err),
      .if_rdata      (if_rdata),
      .ls_req_valid  (ls_req_valid),
      .ls_req_ready  (ls_req_ready),
      .ls_addr       (ls_addr),
      .ls_wen        (ls_wen),
      .ls_wdata      (ls_wdata),
      .ls_wmask      (ls_wmask),
      .ls_rmask      (ls_rmask),
      .ls_resp_valid (ls_resp_valid),
      .ls_resp_err   (ls_resp_err),
      .ls_rdata      (ls_rdata),
      .mem_req_valid (mem_req_valid),
      .mem_req_ready (mem_req_ready),
      .mem_addr      (mem_addr),
      .mem_wen       (mem_wen),
      .mem_wdata     (mem_wdata),
      .mem_wmask     (mem_wmask),
      .mem_rmask     (mem_rmask),
      .mem_resp_valid(mem_resp_valid),
      .mem_rdata     (mem_rdata)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Let combinational outputs settle before sampling.
   task automatic settle();
      #1;
   endtask

   initial begin
      rst            = 1'b1;
      if_req_valid   = 1'b0;
      if_addr        = '0;
      ls_req_valid   = 1'b0;
      ls_addr        = '0;
      ls_wen         = 1'b0;
      ls_wdata       = '0;
      ls_wmask       = '0;
      ls_rmask       = '0;
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_rdata      = '0;

      // ---------------- reset state ----------------
      step(); step();
      rst = 1'b0;
      settle();
      check("rst_readies",   {if_req_ready, ls_req_ready}, 0);
      check("rst_mem_valid", mem_req_valid, 0);
      check("rst_mem_addr",  mem_addr, 0);
      check("rst_mem_fields", {mem_wen, mem_wdata, mem_wmask, mem_rmask}, 0);
      check("rst_resp", {if_resp_valid, if_resp_err, ls_resp_valid, ls_resp_err}, 0);
      check("rst_rdata", {if_rdata, ls_rdata}, 0);

      // ---------------- 1: IF-only read ----------------
      step();
      if_req_valid = 1'b1;
      if_addr      = 32'h8000_0000;
      settle();
      check("t1_if_ready", if_req_ready, 1);
      check("t1_ls_ready", ls_req_ready, 0);
      step();
      if_req_valid  = 1'b0;
      mem_req_ready = 1'b1;
      settle();
      check("t1_if_ready_off", if_req_ready, 0);
      check("t1_mem_valid", mem_req_valid, 1);
      check("t1_mem_addr",  mem_addr, 32'h8000_0000);
      check("t1_mem_wen",   mem_wen, 0);
      check("t1_mem_wdata_wmask", {mem_wdata, mem_wmask}, 0);
      check("t1_mem_rmask", mem_rmask, LW);
      step();
      mem_req_ready = 1'b0;
      settle();
      check("t1_resp_wait0", {mem_req_valid, if_resp_valid}, 0);
      step();
      settle();
      check("t1_resp_wait1", if_resp_valid, 0);
      step();
      mem_resp_valid = 1'b1;
      mem_rdata      = 32'h0010_0073;
      settle();
      check("t1_if_resp",  if_resp_valid, 1);
      check("t1_if_rdata", if_rdata, 32'h0010_0073);
      check("t1_if_err",   if_resp_err, 0);
      check("t1_ls_quiet", {ls_resp_valid, ls_rdata}, 0);
      step();
      mem_resp_valid = 1'b0;
      settle();
      check("t1_if_resp_pulse", if_resp_valid, 0);

      // ---------------- 2: conflict round-robin ----------------
      if_req_valid = 1'b1;
      if_addr      = 32'h0000_0100;
      ls_req_valid = 1'b1;
      ls_addr      = 32'h0000_0200;
      ls_wen       = 1'b0;
      ls_rmask     = 3'b100;
      settle();
      check("t2_c1_ls_ready", ls_req_ready, 1);
      check("t2_c1_if_ready", if_req_ready, 0);
      step();
      ls_req_valid  = 1'b0;
      mem_req_ready = 1'b1;
      settle();
      check("t2_c1_mem_addr",  mem_addr, 32'h0000_0200);
      check("t2_c1_mem_rmask", mem_rmask, 3'b100);
      check("t2_c1_if_wait",   if_req_ready, 0);
      step();
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b1;
      mem_rdata      = 32'h0000_a5a5;
      settle();
      check("t2_c1_ls_resp",  ls_resp_valid, 1);
      check("t2_c1_ls_rdata", ls_rdata, 32'h0000_a5a5);
      check("t2_c1_if_quiet", {if_resp_valid, if_rdata}, 0);
      check("t2_no_grant_on_resp", if_req_ready, 0);
      step();
      mem_resp_valid = 1'b0;
      ls_req_valid   = 1'b1;
      settle();
      check("t2_c2_if_ready", if_req_ready, 1);
      check("t2_c2_ls_ready", ls_req_ready, 0);
      step();
      if_req_valid  = 1'b0;
      mem_req_ready = 1'b1;
      settle();
      check("t2_c2_mem_addr",  mem_addr, 32'h0000_0100);
      check("t2_c2_mem_rmask", mem_rmask, LW);
      step();
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b1;
      mem_rdata      = 32'h0000_1234;
      settle();
      check("t2_c2_if_resp",  {if_resp_valid, if_rdata}, {1'b1, 32'h0000_1234});
      check("t2_c2_ls_quiet", ls_resp_valid, 0);
      step();
      mem_resp_valid = 1'b0;
      if_req_valid   = 1'b1;
      ls_addr        = 32'h0000_0010;
      settle();
      check("t2_c3_ls_ready", ls_req_ready, 1);
      check("t2_c3_if_ready", if_req_ready, 0);

      // ---------------- 6: input churn after grant ----------------
      step();
      ls_addr      = 32'h0000_0020;
      ls_req_valid = 1'b0;
      if_req_valid = 1'b0;
      settle();
      check("t6_mem_valid", mem_req_valid, 1);
      check("t6_addr_req0", mem_addr, 32'h0000_0010);
      step();
      settle();
      check("t6_addr_req1", mem_addr, 32'h0000_0010);
      mem_req_ready = 1'b1;
      settle();
      check("t6_addr_accept", mem_addr, 32'h0000_0010);
      step();
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b1;
      mem_rdata      = 32'h0000_0077;
      settle();
      check("t6_ls_resp", {ls_resp_valid, ls_rdata}, {1'b1, 32'h0000_0077});
      step();
      mem_resp_valid = 1'b0;

      // ---------------- 3: store with stalled acceptance ----------------
      ls_req_valid = 1'b1;
      ls_wen       = 1'b1;
      ls_addr      = 32'h8000_1000;
      ls_wdata     = 32'hdead_beef;
      ls_wmask     = 8'h0f;
      ls_rmask     = 3'b000;
      settle();
      check("t3_ls_ready", ls_req_ready, 1);
      step();
      ls_req_valid = 1'b0;
      ls_wdata     = 32'h0;
      ls_wmask     = 8'hff;
      ls_addr      = 32'h0000_0004;
      for (int i = 0; i < 5; i++) begin
         settle();
         check("t3_hold_valid", mem_req_valid, 1);
         check("t3_hold_fields", {mem_addr, mem_wen, mem_wdata, mem_wmask},
               {32'h8000_1000, 1'b1, 32'hdead_beef, 8'h0f});
         step();
      end
      mem_req_ready = 1'b1;
      settle();
      check("t3_accept_valid", mem_req_valid, 1);
      step();
      mem_req_ready = 1'b0;
      settle();
      check("t3_wait_ack", ls_resp_valid, 0);
      step();
      mem_resp_valid = 1'b1;
      mem_rdata      = 32'h0000_0055;
      settle();
      check("t3_ack", {ls_resp_valid, ls_resp_err}, 2'b10);
      step();
      mem_resp_valid = 1'b0;
      settle();
      check("t3_ack_pulse", ls_resp_valid, 0);

      // ---------------- 4: response timeout ----------------
      if_req_valid = 1'b1;
      if_addr      = 32'h8000_0004;
      settle();
      check("t4_if_ready", if_req_ready, 1);
      step();
      if_req_valid  = 1'b0;
      mem_req_ready = 1'b1;
      mem_rdata     = 32'hffff_ffff;
      step();
      mem_req_ready = 1'b0;
      for (int i = 0; i < TIMEOUT - 1; i++) begin
         settle();
         check("t4_waiting", {if_resp_valid, if_resp_err}, 0);
         step();
      end
      settle();
      check("t4_abort_valid", if_resp_valid, 1);
      check("t4_abort_err",   if_resp_err, 1);
      check("t4_abort_rdata", if_rdata, 0);
      check("t4_ls_quiet",    {ls_resp_valid, ls_resp_err}, 0);
      step();
      mem_resp_valid = 1'b1;
      settle();
      check("t4_late_resp_ignored", {if_resp_valid, if_resp_err, ls_resp_valid, ls_resp_err}, 0);
      check("t4_late_rdata", {if_rdata, ls_rdata}, 0);
      step();
      mem_resp_valid = 1'b0;
      settle();
      check("t4_still_idle", mem_req_valid, 0);

      // ---------------- 5: reset during RESP ----------------
      if_req_valid = 1'b1;
      if_addr      = 32'h8000_0008;
      settle();
      check("t5_if_ready", if_req_ready, 1);
      step();
      if_req_valid  = 1'b0;
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      rst           = 1'b1;
      settle();
      check("t5_no_pulse_in_rst", if_resp_valid, 0);
      step();
      rst            = 1'b0;
      mem_resp_valid = 1'b1;
      mem_rdata      = 32'h0000_cafe;
      settle();
      check("t5_dropped_resp", {if_resp_valid, ls_resp_valid, if_rdata, ls_rdata}, 0);
      check("t5_mem_cleared", {mem_req_valid, mem_addr, mem_wen, mem_rmask}, 0);
      step();
      mem_resp_valid = 1'b0;
      if_req_valid   = 1'b1;
      if_addr        = 32'h8000_0010;
      settle();
      check("t5_fresh_ready", if_req_ready, 1);
      step();
      if_req_valid  = 1'b0;
      mem_req_ready = 1'b1;
      settle();
      check("t5_fresh_mem", {mem_req_valid, mem_addr}, {1'b1, 32'h8000_0010});
      step();
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b1;
      mem_rdata      = 32'h0000_0013;
      settle();
      check("t5_fresh_resp", {if_resp_valid, if_resp_err, if_rdata}, {2'b10, 32'h0000_0013});
      step();
      mem_resp_valid = 1'b0;
      settle();
      check("t5_fresh_pulse", if_resp_valid, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
